nand_bus_sequencer: RTL and testbench

- Pin-level NAND bus cycle engine. Sits directly downstream of the APB register front-end of NAND_controller.
- Accepts one byte-level operation at a time: command latch, address latch, data write, data read, wait-for-ready, chip release.
- Drives nCE/CLE/ALE/nWE/nRE/nWP and the IO bus with programmable, parameterised setup/pulse/hold timing counted in PCLK cycles.
- Returns read bytes and ready/busy status upstream.

---
 rtl/nand_pkg.sv | 42 ++++
 rtl/nand_bus_sequencer_if.sv | 25 ++
 rtl/nand_bus_sequencer.sv | 246 ++++++++++++++++++++++++
 tb/tb_nand_bus_sequencer.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/nand_pkg.sv
// Shared definitions for the NAND bus sequencer and the NAND controller above it:
// operation codes, sequencer state encoding and default pin timing.
package nand_pkg;

    // Default pin timing in PCLK cycles, shared with NAND_controller.
    localparam int T_SETUP_DEF    = 1;
    localparam int T_WP_DEF       = 2;
    localparam int T_WH_DEF       = 2;
    localparam int T_RP_DEF       = 2;
    localparam int T_REH_DEF      = 2;
    localparam int T_WB_DEF       = 4;
    localparam int RB_TIMEOUT_DEF = 65535;
    localparam int CNT_W_DEF      = 16;

    // Byte-level operations; codes 6 and 7 are reserved and ignored.
    typedef enum logic [2:0] {
        OP_CMD     = 3'd0,
        OP_ADDR    = 3'd1,
        OP_WDATA   = 3'd2,
        OP_RDATA   = 3'd3,
        OP_WAIT_RB = 3'd4,
        OP_CE_OFF  = 3'd5
    } op_e;

    // Bus cycle engine states.
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SETUP   = 3'd1,
        ST_WE_LO   = 3'd2,
        ST_WE_HI   = 3'd3,
        ST_RE_LO   = 3'd4,
        ST_RE_HI   = 3'd5,
        ST_WB_WAIT = 3'd6,
        ST_RB_POLL = 3'd7
    } state_e;

    // True for the operations that drive a byte onto IO with an nWE pulse.
    function automatic logic is_write_op(logic [2:0] op);
        return (op == OP_CMD) || (op == OP_ADDR) || (op == OP_WDATA);
    endfunction

endpackage

// File: rtl/nand_bus_sequencer_if.sv
// Upstream request/response channel between the register front-end (master)
// and the NAND bus sequencer (slave).
interface nand_bus_sequencer_if;

    logic       req_valid;
    logic       req_ready;
    logic [2:0] req_op;
    logic [7:0] req_byte;
    logic       wp_n_in;
    logic       rd_valid;
    logic [7:0] rd_data;
    logic       rb_timeout;
    logic       busy;

    modport master (
        output req_valid, req_op, req_byte, wp_n_in,
        input  req_ready, rd_valid, rd_data, rb_timeout, busy
    );

    modport slave (
        input  req_valid, req_op, req_byte, wp_n_in,
        output req_ready, rd_valid, rd_data, rb_timeout, busy
    );

endinterface

// File: rtl/nand_bus_sequencer.sv
// Pin-level NAND bus cycle engine: runs one byte-level operation at a time
// (command/address/data write, data read, wait-for-ready, chip release) with
// setup/pulse/hold timing counted by a single down-counter. All NAND pins are
// driven straight from flops.
module nand_bus_sequencer
    import nand_pkg::*;
#(
    parameter int T_SETUP    = T_SETUP_DEF,
    parameter int T_WP       = T_WP_DEF,
    parameter int T_WH       = T_WH_DEF,
    parameter int T_RP       = T_RP_DEF,
    parameter int T_REH      = T_REH_DEF,
    parameter int T_WB       = T_WB_DEF,
    parameter int RB_TIMEOUT = RB_TIMEOUT_DEF,
    parameter int CNT_W      = CNT_W_DEF
) (
    input  logic                  PCLK,
    input  logic                  PRESET,
    nand_bus_sequencer_if.slave   up,
    input  logic                  RB,
    input  logic [7:0]            IO_IN,
    output logic [7:0]            IO_OUT,
    output logic                  IO_OE,
    output logic                  nCE,
    output logic                  CLE,
    output logic                  ALE,
    output logic                  nWE,
    output logic                  nRE,
    output logic                  nWP
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    // Counter load value for a phase lasting t cycles.
    function automatic logic [CNT_W-1:0] phase_len(int t);
        return CNT_W'(t - 1);
    endfunction

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             rd_op_q, rd_op_d;
    logic             nce_q, nce_d;
    logic             cle_q, cle_d;
    logic             ale_q, ale_d;
    logic             nwe_q, nwe_d;
    logic             nre_q, nre_d;
    logic             nwp_q, nwp_d;
    logic [7:0]       io_out_q, io_out_d;
    logic             io_oe_q, io_oe_d;
    logic [7:0]       rd_data_q, rd_data_d;
    logic             rd_valid_q, rd_valid_d;
    logic             rb_timeout_q, rb_timeout_d;

    logic             cnt_zero;

    assign cnt_zero = (cnt_q == '0);

    // Next-state and next-pin computation for the operation FSM.
    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves
        // it unassigned, which would otherwise infer a latch.
        state_d      = state_q;
        cnt_d        = cnt_q;
        rd_op_d      = rd_op_q;
        nce_d        = nce_q;
        cle_d        = cle_q;
        ale_d        = ale_q;
        nwe_d        = nwe_q;
        nre_d        = nre_q;
        nwp_d        = up.wp_n_in;
        io_out_d     = io_out_q;
        io_oe_d      = io_oe_q;
        rd_data_d    = rd_data_q;
        rd_valid_d   = 1'b0;
        rb_timeout_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // req_ready is high in IDLE, so req_valid alone means accept.
                if (up.req_valid) begin
                    if (is_write_op(up.req_op)) begin
                        state_d  = ST_SETUP;
                        cnt_d    = phase_len(T_SETUP);
                        rd_op_d  = 1'b0;
                        nce_d    = 1'b0;
                        cle_d    = (up.req_op == OP_CMD);
                        ale_d    = (up.req_op == OP_ADDR);
                        io_out_d = up.req_byte;
                        io_oe_d  = 1'b1;
                    end else begin
                        case (up.req_op)
                            OP_RDATA: begin
                                state_d = ST_SETUP;
                                cnt_d   = phase_len(T_SETUP);
                                rd_op_d = 1'b1;
                                nce_d   = 1'b0;
                                cle_d   = 1'b0;
                                ale_d   = 1'b0;
                                io_oe_d = 1'b0;
                            end
                            OP_WAIT_RB: begin
                                state_d = ST_WB_WAIT;
                                cnt_d   = phase_len(T_WB);
                            end
                            OP_CE_OFF: nce_d = 1'b1;
                            default: ;  // reserved codes are consumed and ignored
                        endcase
                    end
                end
            end

            ST_SETUP: begin
                if (!cnt_zero) begin
                    cnt_d = cnt_q - CNT_ONE;
                end else if (rd_op_q) begin
                    state_d = ST_RE_LO;
                    cnt_d   = phase_len(T_RP);
                    nre_d   = 1'b0;
                end else begin
                    state_d = ST_WE_LO;
                    cnt_d   = phase_len(T_WP);
                    nwe_d   = 1'b0;
                end
            end

            ST_WE_LO: begin
                if (!cnt_zero) begin
                    cnt_d = cnt_q - CNT_ONE;
                end else begin
                    state_d = ST_WE_HI;
                    cnt_d   = phase_len(T_WH);
                    nwe_d   = 1'b1;
                end
            end

            ST_WE_HI: begin
                // CLE/ALE/IO stay put through the hold phase, then release.
                if (!cnt_zero) begin
                    cnt_d = cnt_q - CNT_ONE;
                end else begin
                    state_d = ST_IDLE;
                    cle_d   = 1'b0;
                    ale_d   = 1'b0;
                    io_oe_d = 1'b0;
                end
            end

            ST_RE_LO: begin
                // The byte is captured on the last cycle nRE is still low.
                if (!cnt_zero) begin
                    cnt_d = cnt_q - CNT_ONE;
                end else begin
                    state_d   = ST_RE_HI;
                    cnt_d     = phase_len(T_REH);
                    nre_d     = 1'b1;
                    rd_data_d = IO_IN;
                end
            end

            ST_RE_HI: begin
                if (!cnt_zero) begin
                    cnt_d = cnt_q - CNT_ONE;
                end else begin
                    state_d    = ST_IDLE;
                    rd_valid_d = 1'b1;
                end
            end

            ST_WB_WAIT: begin
                // RB is not trusted until the device has had tWB to pull it low.
                if (!cnt_zero) begin
                    cnt_d = cnt_q - CNT_ONE;
                end else begin
                    state_d = ST_RB_POLL;
                    cnt_d   = phase_len(RB_TIMEOUT);
                end
            end

            ST_RB_POLL: begin
                if (RB) begin
                    state_d = ST_IDLE;
                end else if (cnt_zero) begin
                    state_d      = ST_IDLE;
                    rb_timeout_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    // State, counter and pin registers with synchronous reset.
    always_ff @(posedge PCLK) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge values regardless of statement order.
        if (PRESET) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            rd_op_q      <= 1'b0;
            nce_q        <= 1'b1;
            cle_q        <= 1'b0;
            ale_q        <= 1'b0;
            nwe_q        <= 1'b1;
            nre_q        <= 1'b1;
            nwp_q        <= 1'b0;
            io_out_q     <= 8'h00;
            io_oe_q      <= 1'b0;
            rd_data_q    <= 8'h00;
            rd_valid_q   <= 1'b0;
            rb_timeout_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            rd_op_q      <= rd_op_d;
            nce_q        <= nce_d;
            cle_q        <= cle_d;
            ale_q        <= ale_d;
            nwe_q        <= nwe_d;
            nre_q        <= nre_d;
            nwp_q        <= nwp_d;
            io_out_q     <= io_out_d;
            io_oe_q      <= io_oe_d;
            rd_data_q    <= rd_data_d;
            rd_valid_q   <= rd_valid_d;
            rb_timeout_q <= rb_timeout_d;
        end
    end

    assign up.req_ready  = (state_q == ST_IDLE);
    assign up.busy       = (state_q != ST_IDLE);
    assign up.rd_valid   = rd_valid_q;
    assign up.rd_data    = rd_data_q;
    assign up.rb_timeout = rb_timeout_q;

    assign nCE    = nce_q;
    assign CLE    = cle_q;
    assign ALE    = ale_q;
    assign nWE    = nwe_q;
    assign nRE    = nre_q;
    assign nWP    = nwp_q;
    assign IO_OUT = io_out_q;
    assign IO_OE  = io_oe_q;

endmodule

// File: tb/tb_nand_bus_sequencer.sv
// Directed bench for nand_bus_sequencer with default pin timing and a short
// RB timeout (20) so the timeout path is reachable.
module tb_nand_bus_sequencer;
    import nand_pkg::*;

    logic       PCLK = 1'b0;
    logic       PRESET;
    logic       RB;
    logic [7:0] rd_pat;
    logic [7:0] IO_IN;
    logic [7:0] IO_OUT;
    logic       IO_OE, nCE, CLE, ALE, nWE, nRE, nWP;

    nand_bus_sequencer_if up_if ();

    nand_bus_sequencer #(.RB_TIMEOUT(20)) dut (
        .PCLK   (PCLK),
        .PRESET (PRESET),
        .up     (up_if),
        .RB     (RB),
        .IO_IN  (IO_IN),
        .IO_OUT (IO_OUT),
        .IO_OE  (IO_OE),
        .nCE    (nCE),
        .CLE    (CLE),
        .ALE    (ALE),
        .nWE    (nWE),
        .nRE    (nRE),
        .nWP    (nWP)
    );

    always #5 PCLK = ~PCLK;

    // The device only presents the read byte while nRE is low.
    assign IO_IN = nRE ? 8'h3C : rd_pat;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Pin monitor on the falling edge: protocol violations and latched bytes.
    int          both_low_cnt = 0;
    int          oe_read_cnt  = 0;
    int          cle_ale_cnt  = 0;
    int          nce_hi_cnt   = 0;
    int          ale_cnt      = 0;
    bit          watch        = 1'b0;
    logic        prev_nwe     = 1'b1;
    logic [9:0]  latch_log[$];

    always @(negedge PCLK) begin
        if (!nWE && !nRE) both_low_cnt++;
        if (IO_OE && !nRE) oe_read_cnt++;
        if (CLE && ALE) cle_ale_cnt++;
        if (watch && nCE) nce_hi_cnt++;
        if (watch && ALE) ale_cnt++;
        if (!prev_nwe && nWE) latch_log.push_back({CLE, ALE, IO_OUT});
        prev_nwe = nWE;
    end

    task automatic tick();
        @(posedge PCLK);
        #1;
    endtask

    task automatic issue(input logic [2:0] op, input logic [7:0] b);
        up_if.req_valid = 1'b1;
        up_if.req_op    = op;
        up_if.req_byte  = b;
        tick();
        up_if.req_valid = 1'b0;
    endtask

    task automatic wait_ready(input string tag, input int max_cycles);
        int n = 0;
        while (!up_if.req_ready && n < max_cycles) begin
            tick();
            n++;
        end
        check({tag, "_ready"}, up_if.req_ready, 1);
    endtask

    // One write op: sample k=0 right after accept, then k=1..7.
    task automatic write_profile(input string tag, input logic [2:0] op, input logic [7:0] b);
        int nwe_lo = 0, nwe_first = -1, oe_hi = 0, cle_hi = 0, ale_hi = 0;
        int ready_at = -1, io_bad = 0;
        check({tag, "_pre_ready"}, up_if.req_ready, 1);
        issue(op, b);
        check({tag, "_k0_pins"}, {nCE, CLE, ALE, IO_OE, nWE},
              {1'b0, op == OP_CMD, op == OP_ADDR, 1'b1, 1'b1});
        check({tag, "_k0_io"}, IO_OUT, b);
        for (int k = 1; k <= 7; k++) begin
            tick();
            if (!nWE) begin
                nwe_lo++;
                if (nwe_first < 0) nwe_first = k;
            end
            if (IO_OE) oe_hi++;
            if (CLE) cle_hi++;
            if (ALE) ale_hi++;
            if (IO_OE && IO_OUT !== b) io_bad++;
            if (up_if.req_ready && ready_at < 0) ready_at = k;
        end
        check({tag, "_nwe_lo_cycles"}, nwe_lo, 2);
        check({tag, "_nwe_first"}, nwe_first, 1);
        check({tag, "_oe_cycles"}, oe_hi, 4);
        check({tag, "_cle_cycles"}, cle_hi, (op == OP_CMD) ? 4 : 0);
        check({tag, "_ale_cycles"}, ale_hi, (op == OP_ADDR) ? 4 : 0);
        check({tag, "_io_stable"}, io_bad, 0);
        check({tag, "_ready_at"}, ready_at, 5);
        check({tag, "_nce_after"}, nCE, 0);
    endtask

    // WAIT_RB: RB goes high after sample rb_rise_k (-1 = never).
    task automatic rb_run(input string tag, input int rb_rise_k, input int exp_drop, input int exp_to);
        int drop = -1, to_cnt = 0, to_at = -1;
        logic nce_before;
        nce_before = nCE;
        RB = (rb_rise_k == 0);
        issue(OP_WAIT_RB, 8'h00);
        check({tag, "_k0_busy"}, up_if.busy, 1);
        check({tag, "_k0_nce"}, nCE, nce_before);
        for (int k = 1; k <= 40; k++) begin
            if (rb_rise_k >= 0 && k - 1 >= rb_rise_k) RB = 1'b1;
            tick();
            if (up_if.rb_timeout) begin
                to_cnt++;
                if (to_at < 0) to_at = k;
            end
            if (!up_if.busy && drop < 0) drop = k;
        end
        check({tag, "_busy_drop"}, drop, exp_drop);
        check({tag, "_timeouts"}, to_cnt, exp_to);
        if (exp_to != 0) check({tag, "_timeout_at"}, to_at, exp_drop);
        RB = 1'b1;
    endtask

    logic [2:0] b2b_op[4]   = '{OP_CMD, OP_ADDR, OP_ADDR, OP_CMD};
    logic [7:0] b2b_byte[4] = '{8'h00, 8'h12, 8'h34, 8'h30};
    logic [7:0] wp_pat      = 8'b1011_0010;

    initial begin
        int rv_cnt, rv_at, oe_hi, nre_lo, nwe_lo;
        logic [7:0] rd_at_valid;
        logic [9:0] exp_entry;

        PRESET          = 1'b1;
        RB              = 1'b1;
        rd_pat          = 8'h00;
        up_if.req_valid = 1'b0;
        up_if.req_op    = 3'd0;
        up_if.req_byte  = 8'h00;
        up_if.wp_n_in   = 1'b1;
        tick();
        tick();

        // Reset state
        check("rst_pins", {nCE, CLE, ALE, nWE, nRE, nWP, IO_OE}, 7'b1001100);
        check("rst_io_out", IO_OUT, 8'h00);
        check("rst_rd_data", up_if.rd_data, 8'h00);
        check("rst_pulses", {up_if.rd_valid, up_if.rb_timeout}, 2'b00);
        check("rst_ready_busy", {up_if.req_ready, up_if.busy}, 2'b10);
        PRESET = 1'b0;
        tick();
        check("nwp_after_rst", nWP, 1);

        // CMD 0xFF timing profile
        write_profile("cmd_ff", OP_CMD, 8'hFF);

        // Back-to-back CMD/ADDR/ADDR/CMD
        latch_log.delete();
        ale_cnt    = 0;
        nce_hi_cnt = 0;
        watch      = 1'b1;
        for (int i = 0; i < 4; i++) begin
            wait_ready("b2b", 20);
            issue(b2b_op[i], b2b_byte[i]);
        end
        wait_ready("b2b_end", 20);
        watch = 1'b0;
        check("b2b_nce_high", nce_hi_cnt, 0);
        check("b2b_ale_cycles", ale_cnt, 10);
        check("b2b_latch_count", latch_log.size(), 4);
        for (int i = 0; i < 4; i++) begin
            exp_entry = {b2b_op[i] == OP_CMD, b2b_op[i] == OP_ADDR, b2b_byte[i]};
            if (i < latch_log.size()) check($sformatf("b2b_latch%0d", i), latch_log[i], exp_entry);
        end

        // RDATA with 0xA5 presented during nRE low
        rd_pat = 8'hA5;
        check("rd_pre_ready", up_if.req_ready, 1);
        issue(OP_RDATA, 8'h00);
        check("rd_k0_pins", {nCE, CLE, ALE, IO_OE, nRE}, 5'b00001);
        rv_cnt = 0; rv_at = -1; oe_hi = 0; nre_lo = 0; nwe_lo = 0; rd_at_valid = 8'h00;
        for (int k = 1; k <= 7; k++) begin
            tick();
            if (up_if.rd_valid) begin
                rv_cnt++;
                if (rv_at < 0) begin
                    rv_at = k;
                    rd_at_valid = up_if.rd_data;
                end
            end
            if (IO_OE) oe_hi++;
            if (!nRE) nre_lo++;
            if (!nWE) nwe_lo++;
        end
        check("rd_valid_pulses", rv_cnt, 1);
        check("rd_valid_at", rv_at, 5);
        check("rd_data", rd_at_valid, 8'hA5);
        check("rd_oe_cycles", oe_hi, 0);
        check("rd_nre_lo_cycles", nre_lo, 2);
        check("rd_nwe_lo_cycles", nwe_lo, 0);

        // CE_OFF after the read
        check("ceoff_pre_nce", nCE, 0);
        issue(OP_CE_OFF, 8'h00);
        check("ceoff_nce", nCE, 1);
        check("ceoff_ready_busy", {up_if.req_ready, up_if.busy}, 2'b10);

        // WAIT_RB: RB high from the start, high after 10 cycles, stuck low
        rb_run("rb_fast", 0, 5, 0);
        rb_run("rb_10", 10, 11, 0);
        rb_run("rb_stuck", -1, 24, 1);

        // Reserved op is swallowed without leaving IDLE
        issue(3'd6, 8'h55);
        check("reserved_idle", {up_if.req_ready, nCE, IO_OE}, 3'b110);

        // Reset during WE_LO, then a normal command
        issue(OP_CMD, 8'h70);
        tick();
        check("rst_mid_nwe_lo", nWE, 0);
        PRESET = 1'b1;
        tick();
        check("rst_mid_pins", {nWE, nCE, IO_OE, CLE, nWP}, 5'b11000);
        check("rst_mid_ready", up_if.req_ready, 1);
        PRESET = 1'b0;
        write_profile("post_rst", OP_CMD, 8'h90);

        // nWP follows wp_n_in with one cycle of latency across a read
        for (int k = 0; k < 8; k++) begin
            up_if.wp_n_in   = wp_pat[k];
            up_if.req_valid = (k == 0);
            up_if.req_op    = OP_RDATA;
            tick();
            check($sformatf("nwp_k%0d", k), nWP, wp_pat[k]);
        end
        up_if.req_valid = 1'b0;
        wait_ready("wp_end", 20);

        // Whole-run pin invariants
        check("inv_nwe_nre_overlap", both_low_cnt, 0);
        check("inv_oe_during_read", oe_read_cnt, 0);
        check("inv_cle_ale_overlap", cle_ale_cnt, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
